seq_adder: RTL
==============

# seq_adder

Multi-cycle, parametrised binary adder computing `x + y + c_in` over `WIDTH` bits, `CHUNK` bits per clock, with a carry register between chunks. It is the successor to the single-cycle ripple adders: it trades latency for a short critical path of one `CHUNK`-bit ripple. It sits behind valid/ready handshakes on both sides, so it drops into streaming datapaths.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a positive multiple of `CHUNK`.
- `CHUNK`, default 4: bits added per cycle. `N = WIDTH/CHUNK` cycles per operation.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: operands valid.
- `in_ready`, out, 1: block accepts operands this cycle.
- `x`, in, `WIDTH`: operand A.
- `y`, in, `WIDTH`: operand B.
- `c_in`, in, 1: carry in (borrow in when subtracting).
- `sub`, in, 1: subtract select. Present only with `SEQ_ADDER_SUB_EN`.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `s`, out, `WIDTH`: sum.
- `c_out`, out, 1: carry out of the MSB.
- `ovf`, out, 1: signed overflow, defined as carry into MSB XOR carry out of MSB.

## Operation
- FSM has three states:
  - `IDLE`: `in_ready`=1. On `in_valid & in_ready`, capture `x`, `y`, `c_in` (and `sub`), clear chunk counter, go to `RUN`.
  - `RUN`: each cycle, add chunk `cnt` of the captured operands plus the carry register. Write the chunk result into `s[cnt*CHUNK +: CHUNK]`, update the carry register, increment `cnt`. After chunk `N-1`, latch `c_out` and `ovf`, then go to `DONE`.
  - `DONE`: `out_valid`=1. `s`, `c_out` and `ovf` are held stable.
- Leaving `DONE`, on `out_valid & out_ready`:
  - If `in_valid` is also 1, accept new operands directly and go to `RUN`. `in_ready` = `IDLE | (DONE & out_ready)`.
  - Otherwise go to `IDLE`.
- Operands are captured at accept. Input changes during `RUN` or `DONE` are ignored.
- Arithmetic is modulo 2^WIDTH. `c_out` is the final carry. No sign extension.
- `out_ready` held low keeps the FSM in `DONE` indefinitely, with outputs frozen and `in_ready`=0.
- Reset, asserted at any time including mid-`RUN`:
  - State goes to `IDLE`. The operation in flight is discarded.
  - `out_valid`=0, `s`=0, `c_out`=0, `ovf`=0, counter and carry register = 0.
  - `in_ready`=1 while `rst_n` is high and the FSM is in `IDLE`.
- `s` is only meaningful while `out_valid`=1. During `RUN` it shows partial results.

## Timing
- Accept at rising edge E. Chunks are computed at edges E+1 … E+N. `out_valid` rises after edge E+N.
- Latency from accept to `out_valid` is N cycles.
- Throughput is one operation per N+1 cycles with `out_ready` held at 1.
- All outputs are registered, except `in_ready`, which is combinational from state and `out_ready`.
- Critical path is one `CHUNK`-bit ripple plus carry-register setup.
- `CHUNK`=`WIDTH` is legal: N=1, latency 1 cycle.

## Configuration
- `SEQ_ADDER_SUB_EN` defined:
  - `sub` port exists.
  - `sub`=1 computes `x - y - c_in` as `x + ~y + !c_in`.
  - In subtract mode, `c_out`=1 means no borrow. `ovf` is signed subtraction overflow.
- `SEQ_ADDER_SUB_EN` undefined: no `sub` port; the block is add-only.

## Structure
- Package `seq_adder_pkg` holds:
  - the state enum `seq_adder_state_t` (`IDLE`, `RUN`, `DONE`);
  - the function computing `N` and the counter width `$clog2(N)` (minimum 1).
- Sub-module `chunk_adder`: combinational `CHUNK`-bit ripple of full adders. Outputs are sum, carry out, and carry into the MSB (needed for `ovf`). `seq_adder` instantiates it once.

## Test plan
All scenarios use `WIDTH`=8, `CHUNK`=4 (N=2) unless stated.
- 0x0F + 0x01, `c_in`=0 -> `s`=0x10, `c_out`=0, `ovf`=0. `out_valid` rises 2 cycles after accept.
- 0xFF + 0x01, `c_in`=1 -> `s`=0x01, `c_out`=1, `ovf`=0. Also repeat 0x7F + 0x01 -> `s`=0x80, `c_out`=0, `ovf`=1.
- Hold `out_ready`=0 for 5 cycles in `DONE` -> `out_valid`=1 and `s` stable, `in_ready`=0. Then raise `out_ready` with `in_valid`=1 -> new operands accepted that same cycle, next result 2 cycles later.
- Drop `rst_n` one cycle after accept -> `out_valid`=0 and `s`=0 immediately, without waiting for a clock edge. After release, `in_ready`=1 and no stale result ever appears.
- With `SEQ_ADDER_SUB_EN`: 0x05 - 0x07, `c_in`=0, `sub`=1 -> `s`=0xFE, `c_out`=0, `ovf`=0. Also 0x80 - 0x01 -> `s`=0x7F, `c_out`=1, `ovf`=1.
- `WIDTH`=32, `CHUNK`=32 (N=1): 0xFFFFFFFF + 0x00000001 -> `s`=0, `c_out`=1, `out_valid` 1 cycle after accept. Also run 1000 random back-to-back operations against a reference model.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked adder.
package seq_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_adder_state_t;

   // Number of chunk cycles per operation.
   function automatic int calc_n(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Counter width; never below one bit, even when a single chunk covers the word.
   function automatic int calc_cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into its MSB
// so the caller can derive signed overflow.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co    = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle x + y + c_in adder, CHUNK bits per clock, valid/ready on both sides.
// Define SEQ_ADDER_SUB_EN to add the sub port (x - y - c_in as x + ~y + !c_in).
module seq_adder
   import seq_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             c_in,
`ifdef SEQ_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int N  = calc_n(WIDTH, CHUNK);
   localparam int CW = calc_cnt_w(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
   // in_ready is combinational from state and out_ready so a result can be drained
   // and new operands taken on the same edge.

   seq_adder_state_t state, state_next;

   logic [WIDTH-1:0] x_q, y_q, s_next;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [CHUNK-1:0] a_chunk, b_chunk, sum;
   logic             co, c_msb;
   logic             accept;

   assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = RUN;
         RUN:  if (cnt == LAST) state_next = DONE;
         DONE: if (out_ready) state_next = in_valid ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < N; i++) begin
         if (cnt == CW'(i)) begin
            a_chunk = x_q[i*CHUNK +: CHUNK];
            b_chunk = y_q[i*CHUNK +: CHUNK];
         end
      end
   end

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_chunk),
      .b     (b_chunk),
      .ci    (carry),
      .sum   (sum),
      .co    (co),
      .c_msb (c_msb)
   );

   always_comb begin
      s_next = s;
      for (int i = 0; i < N; i++) begin
         if (cnt == CW'(i)) s_next[i*CHUNK +: CHUNK] = sum;
      end
   end

   // Subtraction is folded into the captured operand so RUN is identical for both modes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q       <= '0;
         y_q       <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         s         <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         x_q       <= x;
`ifdef SEQ_ADDER_SUB_EN
         y_q       <= sub ? ~y : y;
         carry     <= sub ? ~c_in : c_in;
`else
         y_q       <= y;
         carry     <= c_in;
`endif
         cnt       <= '0;
         out_valid <= 1'b0;
      end else if (state == RUN) begin
         s     <= s_next;
         carry <= co;
         cnt   <= cnt + CW'(1);
         if (cnt == LAST) begin
            c_out     <= co;
            ovf       <= co ^ c_msb;
            out_valid <= 1'b1;
         end
      end else if ((state == DONE) && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
